id_ex_hazard_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath.
- Latches the decoded control word from the control unit, plus register operands and the immediate, and presents them to the EX stage.
- Contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble.
- Also honours a branch flush and a downstream hold, and keeps a saturating count of inserted bubbles.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_hazard_reg.sv | 189 ++++++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-word layout, field widths and constants.
package mips_pkg;

   localparam int unsigned MEMWRITE_W = 4;
   localparam int unsigned ALUOP_W    = 4;
   localparam int unsigned MRW_W      = 2;

   // Load width encodings carried in memReadWidth.
   localparam logic [MRW_W-1:0] MRW_WORD = 2'd0;
   localparam logic [MRW_W-1:0] MRW_HALF = 2'd1;
   localparam logic [MRW_W-1:0] MRW_BYTE = 2'd2;

   localparam logic [ALUOP_W-1:0] ALUOP_ADD = 4'd3;
   localparam logic [ALUOP_W-1:0] ALUOP_SUB = 4'd4;

   // Decoded control word, MSB first in the order the control unit emits it.
   typedef struct packed {
      logic                  regDst;
      logic                  branch;
      logic                  branchType;
      logic                  memtoReg;
      logic                  aluSrc;
      logic                  aluShiftImm;
      logic                  regWrite;
      logic                  loadImm;
      logic                  zeroEx;
      logic [MEMWRITE_W-1:0] memWrite;
      logic [MRW_W-1:0]      memReadWidth;
      logic [ALUOP_W-1:0]    aluOperation;
   } ctrl_t;

   // All-zero control word: no register write, no store, no branch.
   localparam ctrl_t BUBBLE = '0;

   // The instruction reads rt as a source (R-type, branch compare, store data).
   function automatic logic usesRt(input ctrl_t c);
      return c.regDst | c.branch | (c.memWrite != '0);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register the ID instruction reads.
module hazard_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              exValid,
   input  logic              exMemtoReg,
   input  logic [REG_AW-1:0] exRt,
   input  logic [REG_AW-1:0] idRs,
   input  logic [REG_AW-1:0] idRt,
   input  logic              idUsesRt,
   output logic              hazard
);

   logic exIsLoad;
   logic rsMatch;
   logic rtMatch;

   // $0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign exIsLoad = exValid & exMemtoReg & (exRt != '0);
   assign rsMatch  = (exRt == idRs);
   assign rtMatch  = idUsesRt & (exRt == idRt);

   // Combine: any matched source of a real load stalls.
   always_comb begin
      hazard = exIsLoad & (rsMatch | rtMatch);
   end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall, branch flush, downstream hold
// and a saturating counter of hazard bubbles.
module id_ex_hazard_reg
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_RegDst,
   input  logic                  id_Branch,
   input  logic                  id_BranchType,
   input  logic                  id_MemtoReg,
   input  logic                  id_ALUSrc,
   input  logic                  id_ALUShiftImm,
   input  logic                  id_RegWrite,
   input  logic                  id_LoadImm,
   input  logic                  id_ZeroEx,
   input  logic [MEMWRITE_W-1:0] id_MemWrite,
   input  logic [MRW_W-1:0]      id_memReadWidth,
   input  logic [ALUOP_W-1:0]    id_aluOperation,
   input  logic [DATA_W-1:0]     id_pc4,
   input  logic [DATA_W-1:0]     id_rdata1,
   input  logic [DATA_W-1:0]     id_rdata2,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [REG_AW-1:0]     id_rs,
   input  logic [REG_AW-1:0]     id_rt,
   input  logic [REG_AW-1:0]     id_rd,
   input  logic [REG_AW-1:0]     id_shamt,
   input  logic                  flush_i,
   input  logic                  hold_i,
   output logic                  ex_RegDst,
   output logic                  ex_Branch,
   output logic                  ex_BranchType,
   output logic                  ex_MemtoReg,
   output logic                  ex_ALUSrc,
   output logic                  ex_ALUShiftImm,
   output logic                  ex_RegWrite,
   output logic                  ex_LoadImm,
   output logic                  ex_ZeroEx,
   output logic [MEMWRITE_W-1:0] ex_MemWrite,
   output logic [MRW_W-1:0]      ex_memReadWidth,
   output logic [ALUOP_W-1:0]    ex_aluOperation,
   output logic [DATA_W-1:0]     ex_pc4,
   output logic [DATA_W-1:0]     ex_rdata1,
   output logic [DATA_W-1:0]     ex_rdata2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [REG_AW-1:0]     ex_rs,
   output logic [REG_AW-1:0]     ex_rt,
   output logic [REG_AW-1:0]     ex_rd,
   output logic [REG_AW-1:0]     ex_shamt,
   output logic                  ex_valid,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      bubble_cnt
);

   // Operand/address payload travelling alongside the control word.
   typedef struct packed {
      logic [DATA_W-1:0] pc4;
      logic [DATA_W-1:0] rdata1;
      logic [DATA_W-1:0] rdata2;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] shamt;
   } data_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctrl_t            idCtrl;
   data_t            idData;
   ctrl_t            exCtrlQ, exCtrlD;
   data_t            exDataQ, exDataD;
   logic             exValidQ, exValidD;
   logic [CNT_W-1:0] bubbleCntQ, bubbleCntD;
   logic             hazard;
   logic             idUsesRt;

   assign idCtrl = '{
      regDst:       id_RegDst,
      branch:       id_Branch,
      branchType:   id_BranchType,
      memtoReg:     id_MemtoReg,
      aluSrc:       id_ALUSrc,
      aluShiftImm:  id_ALUShiftImm,
      regWrite:     id_RegWrite,
      loadImm:      id_LoadImm,
      zeroEx:       id_ZeroEx,
      memWrite:     id_MemWrite,
      memReadWidth: id_memReadWidth,
      aluOperation: id_aluOperation
   };

   assign idData = '{
      pc4:    id_pc4,
      rdata1: id_rdata1,
      rdata2: id_rdata2,
      imm:    id_imm,
      rs:     id_rs,
      rt:     id_rt,
      rd:     id_rd,
      shamt:  id_shamt
   };

   assign idUsesRt = usesRt(idCtrl);

   hazard_detect #(
      .REG_AW(REG_AW)
   ) u_hazard_detect (
      .exValid   (exValidQ),
      .exMemtoReg(exCtrlQ.memtoReg),
      .exRt      (exDataQ.rt),
      .idRs      (id_rs),
      .idRt      (id_rt),
      .idUsesRt  (idUsesRt),
      .hazard    (hazard)
   );

   // A flush kills the ID instruction anyway, so a hazard against it need not stall.
   assign stall_o = (hazard & ~flush_i) | hold_i;

   // Next-state selection: flush, then hold, then hazard bubble, else load ID.
   always_comb begin
      exCtrlD    = exCtrlQ;
      exDataD    = exDataQ;
      exValidD   = exValidQ;
      bubbleCntD = bubbleCntQ;
      if (flush_i) begin
         exCtrlD  = BUBBLE;
         exDataD  = '0;
         exValidD = 1'b0;
      end else if (hold_i) begin
         // Freeze everything, including the counter.
      end else if (hazard) begin
         exCtrlD  = BUBBLE;
         exDataD  = '0;
         exValidD = 1'b0;
         if (bubbleCntQ != CNT_MAX) begin
            bubbleCntD = bubbleCntQ + 1'b1;
         end
      end else begin
         exCtrlD  = idCtrl;
         exDataD  = idData;
         exValidD = 1'b1;
      end
   end

   // Pipeline register and bubble counter with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exCtrlQ    <= BUBBLE;
         exDataQ    <= '0;
         exValidQ   <= 1'b0;
         bubbleCntQ <= '0;
      end else begin
         exCtrlQ    <= exCtrlD;
         exDataQ    <= exDataD;
         exValidQ   <= exValidD;
         bubbleCntQ <= bubbleCntD;
      end
   end

   assign ex_RegDst       = exCtrlQ.regDst;
   assign ex_Branch       = exCtrlQ.branch;
   assign ex_BranchType   = exCtrlQ.branchType;
   assign ex_MemtoReg     = exCtrlQ.memtoReg;
   assign ex_ALUSrc       = exCtrlQ.aluSrc;
   assign ex_ALUShiftImm  = exCtrlQ.aluShiftImm;
   assign ex_RegWrite     = exCtrlQ.regWrite;
   assign ex_LoadImm      = exCtrlQ.loadImm;
   assign ex_ZeroEx       = exCtrlQ.zeroEx;
   assign ex_MemWrite     = exCtrlQ.memWrite;
   assign ex_memReadWidth = exCtrlQ.memReadWidth;
   assign ex_aluOperation = exCtrlQ.aluOperation;
   assign ex_pc4          = exDataQ.pc4;
   assign ex_rdata1       = exDataQ.rdata1;
   assign ex_rdata2       = exDataQ.rdata2;
   assign ex_imm          = exDataQ.imm;
   assign ex_rs           = exDataQ.rs;
   assign ex_rt           = exDataQ.rt;
   assign ex_rd           = exDataQ.rd;
   assign ex_shamt        = exDataQ.shamt;
   assign ex_valid        = exValidQ;
   assign bubble_cnt      = bubbleCntQ;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed scenarios plus random traffic against an
// instruction-level model. A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_hazard_reg;

   typedef struct packed {
      logic        regDst, branch, branchType, memtoReg, aluSrc;
      logic        aluShiftImm, regWrite, loadImm, zeroEx;
      logic [3:0]  memWrite;
      logic [1:0]  mrw;
      logic [3:0]  aluOp;
      logic [31:0] pc4, rdata1, rdata2, imm;
      logic [4:0]  rs, rt, rd, shamt;
   } instr_t;

   logic   clk = 1'b0;
   logic   rstN, flush, hold;
   instr_t id;

   instr_t      exObs    [2];
   logic        stallObs [2];
   logic        validObs [2];
   logic [15:0] cntObs   [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : gDut
      localparam int unsigned CW = (g == 0) ? 16 : 2;
      logic [CW-1:0] cntLoc;
      instr_t        exLoc;

      assign exObs[g]  = exLoc;
      assign cntObs[g] = 16'(cntLoc);

      id_ex_hazard_reg #(
         .DATA_W(32),
         .REG_AW(5),
         .CNT_W (CW)
      ) u_dut (
         .clk            (clk),
         .rst_n          (rstN),
         .id_RegDst      (id.regDst),
         .id_Branch      (id.branch),
         .id_BranchType  (id.branchType),
         .id_MemtoReg    (id.memtoReg),
         .id_ALUSrc      (id.aluSrc),
         .id_ALUShiftImm (id.aluShiftImm),
         .id_RegWrite    (id.regWrite),
         .id_LoadImm     (id.loadImm),
         .id_ZeroEx      (id.zeroEx),
         .id_MemWrite    (id.memWrite),
         .id_memReadWidth(id.mrw),
         .id_aluOperation(id.aluOp),
         .id_pc4         (id.pc4),
         .id_rdata1      (id.rdata1),
         .id_rdata2      (id.rdata2),
         .id_imm         (id.imm),
         .id_rs          (id.rs),
         .id_rt          (id.rt),
         .id_rd          (id.rd),
         .id_shamt       (id.shamt),
         .flush_i        (flush),
         .hold_i         (hold),
         .ex_RegDst      (exLoc.regDst),
         .ex_Branch      (exLoc.branch),
         .ex_BranchType  (exLoc.branchType),
         .ex_MemtoReg    (exLoc.memtoReg),
         .ex_ALUSrc      (exLoc.aluSrc),
         .ex_ALUShiftImm (exLoc.aluShiftImm),
         .ex_RegWrite    (exLoc.regWrite),
         .ex_LoadImm     (exLoc.loadImm),
         .ex_ZeroEx      (exLoc.zeroEx),
         .ex_MemWrite    (exLoc.memWrite),
         .ex_memReadWidth(exLoc.mrw),
         .ex_aluOperation(exLoc.aluOp),
         .ex_pc4         (exLoc.pc4),
         .ex_rdata1      (exLoc.rdata1),
         .ex_rdata2      (exLoc.rdata2),
         .ex_imm         (exLoc.imm),
         .ex_rs          (exLoc.rs),
         .ex_rt          (exLoc.rt),
         .ex_rd          (exLoc.rd),
         .ex_shamt       (exLoc.shamt),
         .ex_valid       (validObs[g]),
         .stall_o        (stallObs[g]),
         .bubble_cnt     (cntLoc)
      );
   end

   int unsigned nAssert = 0;
   int unsigned nFail   = 0;

   // Model state: what EX should hold, and how many hazard bubbles were inserted.
   instr_t      mEx;
   bit          mValid;
   int unsigned mCnt;

   task automatic checkEq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nAssert++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit modelHazard();
      bit readsRt;
      readsRt = id.regDst || id.branch || (id.memWrite != 0);
      return mValid && mEx.memtoReg && (mEx.rt != 0) &&
             ((mEx.rt == id.rs) || (readsRt && (mEx.rt == id.rt)));
   endfunction

   // Apply the current inputs for one clock and compare both instances to the model.
   task automatic cycle(input string tag);
      bit          hz;
      instr_t      nEx;
      bit          nValid;
      int unsigned nCnt;
      int unsigned cap;
      #1;
      hz = modelHazard();
      if (rstN) begin
         for (int g = 0; g < 2; g++) begin
            checkEq({tag, "/stall"}, 256'(stallObs[g]), 256'((hz && !flush) || hold));
         end
      end
      nEx = mEx; nValid = mValid; nCnt = mCnt;
      if (!rstN) begin
         nEx = '0; nValid = 0; nCnt = 0;
      end else if (flush) begin
         nEx = '0; nValid = 0;
      end else if (hold) begin
         nEx = mEx;
      end else if (hz) begin
         nEx = '0; nValid = 0; nCnt = mCnt + 1;
      end else begin
         nEx = id; nValid = 1;
      end
      @(posedge clk);
      #1;
      mEx = nEx; mValid = nValid; mCnt = nCnt;
      for (int g = 0; g < 2; g++) begin
         cap = (g == 0) ? 65535 : 3;
         checkEq({tag, "/ex"},    256'(exObs[g]),    256'(mEx));
         checkEq({tag, "/valid"}, 256'(validObs[g]), 256'(mValid));
         checkEq({tag, "/cnt"},   256'(cntObs[g]),   256'((mCnt > cap) ? cap : mCnt));
      end
   endtask

   function automatic instr_t mkLw(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '0;
      i.memtoReg = 1; i.aluSrc = 1; i.regWrite = 1; i.aluOp = 4'd3;
      i.rs = rs; i.rt = rt; i.imm = 32'd4; i.rdata1 = 32'd100; i.pc4 = 32'h40;
      return i;
   endfunction

   function automatic instr_t mkAdd(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [31:0] a,
                                    input logic [31:0] b);
      instr_t i = '0;
      i.regDst = 1; i.regWrite = 1; i.aluOp = 4'd3;
      i.rs = rs; i.rt = rt; i.rd = rd; i.rdata1 = a; i.rdata2 = b; i.pc4 = 32'h44;
      return i;
   endfunction

   function automatic instr_t mkAddi(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '0;
      i.aluSrc = 1; i.regWrite = 1; i.aluOp = 4'd3; i.rs = rs; i.rt = rt; i.imm = 32'd1;
      return i;
   endfunction

   function automatic instr_t mkSw(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '0;
      i.aluSrc = 1; i.memWrite = 4'hF; i.rs = rs; i.rt = rt; i.imm = 32'd8;
      return i;
   endfunction

   function automatic instr_t rndInstr();
      instr_t i;
      i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      i.rs = 5'($urandom_range(0, 3));
      i.rt = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) i.memWrite = '0;
      return i;
   endfunction

   initial begin
      int unsigned cntSave;
      mEx = '0; mValid = 0; mCnt = 0;
      flush = 0; hold = 0;

      // Reset with live-looking inputs.
      rstN = 0;
      id = '0; id.regWrite = 1; id.rdata1 = 32'hDEADBEEF;
      cycle("rst0");
      cycle("rst1");
      checkEq("rst_regwrite", 256'(exObs[0].regWrite), 256'(0));
      checkEq("rst_rdata1",   256'(exObs[0].rdata1),   256'(0));
      rstN = 1;

      // Pass-through of an ADD.
      id = mkAdd(5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      cycle("add");
      checkEq("add_aluop",  256'(exObs[0].aluOp),  256'(3));
      checkEq("add_rdata1", 256'(exObs[0].rdata1), 256'(5));
      checkEq("add_rdata2", 256'(exObs[0].rdata2), 256'(7));
      checkEq("add_valid",  256'(validObs[0]),     256'(1));

      // Load-use: one bubble, then the dependent ADD loads.
      id = mkLw(5'd0, 5'd8);
      cycle("lu_lw");
      id = mkAdd(5'd8, 5'd1, 5'd2, 32'd1, 32'd2);
      #1;
      checkEq("lu_stall", 256'(stallObs[0]), 256'(1));
      cycle("lu_bubble");
      checkEq("lu_valid",    256'(validObs[0]),        256'(0));
      checkEq("lu_regwrite", 256'(exObs[0].regWrite),  256'(0));
      checkEq("lu_cnt",      256'(cntObs[0]),          256'(1));
      checkEq("lu_stall2",   256'(stallObs[0]),        256'(0));
      cycle("lu_load");
      checkEq("lu_rs", 256'(exObs[0].rs), 256'(8));

      // No false hazards on $0 or on an rt that is not read.
      id = mkLw(5'd0, 5'd0);
      cycle("z_lw");
      id = mkAdd(5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
      cycle("z_use");
      id = mkLw(5'd0, 5'd9);
      cycle("i_lw");
      id = mkAddi(5'd1, 5'd9);
      cycle("i_addi");
      id = mkLw(5'd0, 5'd9);
      cycle("s_lw");
      id = mkSw(5'd1, 5'd9);
      cycle("s_sw");
      cycle("s_sw_load");

      // Flush over a hazard: bubble without counting.
      id = mkLw(5'd0, 5'd8);
      cycle("f_lw");
      cntSave = 32'(cntObs[0]);
      id = mkAdd(5'd8, 5'd1, 5'd2, 32'd3, 32'd4);
      flush = 1;
      cycle("f_flush");
      checkEq("f_cnt", 256'(cntObs[0]), 256'(cntSave));
      flush = 0;

      // Hold freezes EX.
      id = mkAdd(5'd1, 5'd2, 5'd3, 32'd11, 32'd22);
      cycle("h_add");
      hold = 1;
      for (int k = 0; k < 3; k++) begin
         id = rndInstr();
         cycle("h_hold");
      end
      checkEq("h_frozen", 256'(exObs[0].rdata2), 256'(22));
      hold = 0;

      // Hold with a simultaneous hazard: frozen, no count.
      id = mkLw(5'd0, 5'd8);
      cycle("hh_lw");
      id = mkAdd(5'd8, 5'd1, 5'd2, 32'd1, 32'd1);
      hold = 1;
      cycle("hh_hold");
      hold = 0;
      cycle("hh_bubble");
      cycle("hh_load");

      // Chained self-dependent loads drive the 2-bit counter into saturation.
      id = mkLw(5'd8, 5'd8);
      for (int k = 0; k < 12; k++) cycle("sat");
      checkEq("sat_cnt2", 256'(cntObs[1]), 256'(3));

      // Reset in the middle of a stall.
      id = mkLw(5'd0, 5'd8);
      cycle("rm_lw");
      id = mkAdd(5'd8, 5'd1, 5'd2, 32'd1, 32'd1);
      rstN = 0;
      cycle("rm_rst");
      rstN = 1;
      cycle("rm_after");

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         id    = rndInstr();
         flush = ($urandom_range(0, 7) == 0);
         hold  = ($urandom_range(0, 7) == 0);
         rstN  = ($urandom_range(0, 63) != 0);
         cycle("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
